// File: rtl/memristor_pulse_sequencer_if.sv
// Command handshake and completion status between the user-area control
// logic (master) and the memristor pulse sequencer (slave).
interface memristor_pulse_sequencer_if #(
  parameter int NCH  = 3,
  parameter int PW_W = 8
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_ch;
  logic [1:0]      cmd_op;
  logic [PW_W-1:0] cmd_width;
  logic [3:0]      cmd_repeat;
  logic            abort;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output cmd_valid, cmd_ch, cmd_op, cmd_width, cmd_repeat, abort,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_op, cmd_width, cmd_repeat, abort,
    output cmd_ready, busy, done, err
  );
endinterface

// File: rtl/memristor_pulse_sequencer.sv
// Drives per-channel SEL/DIGITALIN pins of the memristor core array with
// registered SET/RESET pulses and READ windows, with repeat, gap and abort.
//
// state | meaning
// IDLE  | ready for a command, all drive pins low
// SETUP | DIGITALIN preset one cycle ahead of SEL
// PULSE | SEL asserted (SET/RESET) or read window open (READ)
// GAP   | all drive low between repeated pulses
// DONE  | one-cycle completion, err flags reject/abort
module memristor_pulse_sequencer #(
  parameter int NCH  = 3,
  parameter int PW_W = 8,
  parameter int GAP  = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        rst_n,
  memristor_pulse_sequencer_if.slave  bus,
  output logic [NCH-1:0]              sel_o,
  output logic [NCH-1:0]              din_o,
  output logic                        rd_win
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic [2:0]       r_state;
  logic [CH_W-1:0]  r_ch;
  logic [1:0]       r_op;
  logic [PW_W-1:0]  r_width;
  logic [3:0]       r_rep;
  logic [PW_W-1:0]  r_cnt;
  logic [GAP_W-1:0] r_gcnt;

  logic [2:0]      w_nxt;
  logic            w_err;
  logic [CH_W-1:0] w_ch;
  logic [1:0]      w_op;
  logic            w_sel_en, w_din_en, w_rd, w_busy, w_ready, w_done;
  logic [NCH-1:0]  w_sel, w_din;

  always_comb begin
    w_nxt = r_state;
    w_err = 1'b0;
    case (r_state)
      S_IDLE:
        if (bus.cmd_valid) begin
          if (bus.cmd_op == OP_RSVD || 32'(bus.cmd_ch) >= NCH) begin
            w_nxt = S_DONE;
            w_err = 1'b1;
          end else begin
            w_nxt = S_SETUP;
          end
        end
      S_SETUP: w_nxt = S_PULSE;
      S_PULSE: if (r_cnt == '0) w_nxt = S_GAP;
      S_GAP:   if (r_gcnt == '0) w_nxt = (r_rep != 4'd0) ? S_SETUP : S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (bus.abort && (r_state == S_SETUP || r_state == S_PULSE || r_state == S_GAP)) begin
      w_nxt = S_DONE;
      w_err = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    w_ch     = (r_state == S_IDLE) ? bus.cmd_ch : r_ch;
    w_op     = (r_state == S_IDLE) ? bus.cmd_op : r_op;
    w_sel_en = 1'b0;
    w_din_en = 1'b0;
    w_rd     = 1'b0;
    w_busy   = 1'b1;
    w_ready  = 1'b0;
    w_done   = 1'b0;
    case (w_nxt)
      S_IDLE: begin
        w_busy  = 1'b0;
        w_ready = 1'b1;
      end
      S_SETUP: w_din_en = (w_op == OP_SET);
      S_PULSE: begin
        w_sel_en = (w_op != OP_READ);
        w_din_en = (w_op == OP_SET);
        w_rd     = (w_op == OP_READ);
      end
      S_DONE:  w_done = 1'b1;
      default: w_busy = 1'b1;
    endcase
    for (int i = 0; i < NCH; i++) begin
      w_sel[i] = w_sel_en && (w_ch == CH_W'(i));
      w_din[i] = w_din_en && (w_ch == CH_W'(i));
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ch          <= '0;
      r_op          <= '0;
      r_width       <= '0;
      r_rep         <= '0;
      r_cnt         <= '0;
      r_gcnt        <= '0;
      sel_o         <= '0;
      din_o         <= '0;
      rd_win        <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE) begin
        r_ch    <= bus.cmd_ch;
        r_op    <= bus.cmd_op;
        r_width <= (bus.cmd_width == '0) ? PW_W'(1) : bus.cmd_width;
        r_rep   <= bus.cmd_repeat;
      end
      if (w_nxt == S_PULSE && r_state != S_PULSE) r_cnt <= r_width - PW_W'(1);
      else if (r_state == S_PULSE && r_cnt != '0) r_cnt <= r_cnt - PW_W'(1);
      if (w_nxt == S_GAP && r_state != S_GAP) r_gcnt <= GAP_W'(GAP - 1);
      else if (r_state == S_GAP && r_gcnt != '0) r_gcnt <= r_gcnt - GAP_W'(1);
      if (r_state == S_GAP && w_nxt == S_SETUP) r_rep <= r_rep - 4'd1;
      sel_o         <= w_sel;
      din_o         <= w_din;
      rd_win        <= w_rd;
      bus.cmd_ready <= w_ready;
      bus.busy      <= w_busy;
      bus.done      <= w_done;
      bus.err       <= w_done && w_err;
    end
  end
endmodule

// File: tb/tb_memristor_pulse_sequencer.sv
// Directed bench for memristor_pulse_sequencer (NCH=3, PW_W=8, GAP=4):
// per-cycle output vectors against hand-derived expected sequences.
module tb_memristor_pulse_sequencer;
  logic clk_sys = 1'b0;
  logic rst_n;
  logic [2:0] sel_o, din_o;
  logic rd_win;
  int n_cmp = 0;
  int n_err = 0;

  memristor_pulse_sequencer_if #(.NCH(3), .PW_W(8)) bus ();

  memristor_pulse_sequencer #(.NCH(3), .PW_W(8), .GAP(4)) dut (
    .wb_clk_i (clk_sys),
    .rst_n    (rst_n),
    .bus      (bus),
    .sel_o    (sel_o),
    .din_o    (din_o),
    .rd_win   (rd_win)
  );

  always #5 clk_sys = ~clk_sys;

  // {ready, busy, done, err, rd_win, sel[2:0], din[2:0]}
  function automatic logic [10:0] pk(logic rdy, logic bsy, logic dn, logic er,
                                     logic rd, logic [2:0] sel, logic [2:0] din);
    return {rdy, bsy, dn, er, rd, sel, din};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.cmd_ready, bus.busy, bus.done, bus.err, rd_win, sel_o, din_o};
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Builds the expected per-cycle trace from the command, then drives it.
  // cmd_valid stays high until done is expected, so held-valid must be ignored.
  task automatic run_cmd(string name, logic [1:0] ch, logic [1:0] op,
                         logic [7:0] width, logic [3:0] rep);
    logic [10:0] q[$];
    logic [2:0] oh;
    int w;
    w  = (width == 8'd0) ? 1 : int'(width);
    oh = 3'b001 << ch;
    if (op == 2'b11 || ch >= 2'd3) begin
      q.push_back(pk(0, 1, 1, 1, 0, 3'b000, 3'b000));
    end else begin
      for (int r = 0; r <= int'(rep); r++) begin
        q.push_back(pk(0, 1, 0, 0, 0, 3'b000, (op == 2'b00) ? oh : 3'b000));
        for (int i = 0; i < w; i++)
          q.push_back(pk(0, 1, 0, 0, op == 2'b10, (op != 2'b10) ? oh : 3'b000,
                         (op == 2'b00) ? oh : 3'b000));
        for (int i = 0; i < 4; i++) q.push_back(pk(0, 1, 0, 0, 0, 3'b000, 3'b000));
      end
      q.push_back(pk(0, 1, 1, 0, 0, 3'b000, 3'b000));
    end
    q.push_back(pk(1, 0, 0, 0, 0, 3'b000, 3'b000));
    bus.cmd_ch     = ch;
    bus.cmd_op     = op;
    bus.cmd_width  = width;
    bus.cmd_repeat = rep;
    bus.cmd_valid  = 1'b1;
    for (int c = 0; c < q.size(); c++) begin
      step();
      check_val($sformatf("%s_c%0d", name, c), 32'(obs()), 32'(q[c]));
      if (q[c][8]) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_ch = '0;
    bus.cmd_op = '0;
    bus.cmd_width = '0;
    bus.cmd_repeat = '0;
    bus.abort = 1'b0;
    #12;
    check_val("reset_held", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 3'b000, 3'b000)));
    @(negedge clk_sys);
    rst_n = 1'b1;
    step();
    check_val("reset_idle", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 3'b000, 3'b000)));

    run_cmd("set_ch2_w5", 2'd2, 2'b00, 8'd5, 4'd0);
    run_cmd("reset_ch0_w3_r2", 2'd0, 2'b01, 8'd3, 4'd2);
    run_cmd("read_ch1_w0", 2'd1, 2'b10, 8'd0, 4'd0);
    run_cmd("rej_ch3", 2'd3, 2'b00, 8'd4, 4'd0);
    run_cmd("rej_op11", 2'd1, 2'b11, 8'd4, 4'd0);

    // abort on PULSE cycle 10 of a long SET
    bus.cmd_ch = 2'd0; bus.cmd_op = 2'b00; bus.cmd_width = 8'd200; bus.cmd_repeat = 4'd0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check_val("abort_setup", 32'(obs()), 32'(pk(0, 1, 0, 0, 0, 3'b000, 3'b001)));
    for (int c = 1; c <= 10; c++) begin
      step();
      check_val($sformatf("abort_pulse%0d", c), 32'(obs()), 32'(pk(0, 1, 0, 0, 0, 3'b001, 3'b001)));
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_val("abort_done", 32'(obs()), 32'(pk(0, 1, 1, 1, 0, 3'b000, 3'b000)));
    step();
    check_val("abort_idle", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 3'b000, 3'b000)));

    // abort coinciding with the last GAP cycle still reports err
    bus.cmd_ch = 2'd0; bus.cmd_op = 2'b01; bus.cmd_width = 8'd1; bus.cmd_repeat = 4'd0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check_val("gabort_setup", 32'(obs()), 32'(pk(0, 1, 0, 0, 0, 3'b000, 3'b000)));
    step();
    check_val("gabort_pulse", 32'(obs()), 32'(pk(0, 1, 0, 0, 0, 3'b001, 3'b000)));
    for (int c = 2; c <= 5; c++) begin
      step();
      check_val($sformatf("gabort_gap%0d", c), 32'(obs()), 32'(pk(0, 1, 0, 0, 0, 3'b000, 3'b000)));
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_val("gabort_done", 32'(obs()), 32'(pk(0, 1, 1, 1, 0, 3'b000, 3'b000)));
    step();
    check_val("gabort_idle", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 3'b000, 3'b000)));

    bus.abort = 1'b1;
    step();
    check_val("abort_in_idle", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 3'b000, 3'b000)));
    bus.abort = 1'b0;

    // asynchronous reset in the middle of a pulse
    bus.cmd_ch = 2'd1; bus.cmd_op = 2'b00; bus.cmd_width = 8'd20; bus.cmd_repeat = 4'd0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    check_val("mid_pulse", 32'(obs()), 32'(pk(0, 1, 0, 0, 0, 3'b010, 3'b010)));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 3'b000, 3'b000)));
    #1;
    rst_n = 1'b1;
    step();
    check_val("post_rst_idle", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 3'b000, 3'b000)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
